wiper_ctrl_param: RTL

Parametrised rain-sensing windshield-wiper controller for the board top level. It counts active rain sensors, classifies rain intensity against programmable thresholds with separate up/down persistence (hysteresis), and drives an off/slow/fast wiper state. It also produces per-sweep pulses and a wrapping sweep counter, and accepts a manual override mode. It runs from clk_2 through an internal tick divider. SWI, LED and SEG wiring stays in top.

---
 rtl/wiper_ctrl_param.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wiper_ctrl_param.sv
// rtl/wiper_ctrl_param.sv - rain-sensing wiper controller with hysteresis, sweep timing and manual override
module wiper_ctrl_param #(
  parameter int NSENS       = 7,
  parameter int DIV         = 2,
  parameter int SLOW_TH     = 3,
  parameter int FAST_TH     = 5,
  parameter int UP_HOLD     = 3,
  parameter int DOWN_HOLD   = 2,
  parameter int SLOW_PERIOD = 4,
  parameter int FAST_PERIOD = 2
) (
  input  logic                       clk_2,
  input  logic                       reset,
  input  logic [NSENS-1:0]           rain,
  input  logic [1:0]                 mode,
  output logic [1:0]                 state,
  output logic [$clog2(NSENS+1)-1:0] drops,
  output logic                       tick,
  output logic                       wipe,
  output logic [7:0]                 sweeps
);

  localparam int DW   = $clog2(NSENS + 1);
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MAXP = (SLOW_PERIOD > FAST_PERIOD) ? SLOW_PERIOD : FAST_PERIOD;
  localparam int PW   = $clog2(MAXP + 1);
  localparam int MAXH = (UP_HOLD > DOWN_HOLD) ? UP_HOLD : DOWN_HOLD;
  localparam int HW   = $clog2(MAXH + 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_SLOW = 2'd1,
    S_FAST = 2'd2
  } wstate_t;

  wstate_t        cur, cand, level, target, nxt, cand_nxt;
  logic [CW-1:0]  divcnt;
  logic [HW-1:0]  hcnt, hcnt_nxt;
  logic [HW:0]    n;
  logic [PW-1:0]  pcnt;
  int             req;
  logic           period_end;

  assign state = cur;

  always_comb begin
    level = S_OFF;
    if (int'(drops) >= FAST_TH)      level = S_FAST;
    else if (int'(drops) >= SLOW_TH) level = S_SLOW;

    case (mode)
      2'd1:    target = S_OFF;
      2'd2:    target = S_SLOW;
      2'd3:    target = S_FAST;
      default: target = level;
    endcase
  end

  // Hysteresis: a candidate must persist for req consecutive ticks; a different candidate restarts at 1.
  always_comb begin
    nxt      = cur;
    hcnt_nxt = hcnt;
    cand_nxt = cand;
    n        = '0;
    req      = 0;
    if (mode != 2'd0) begin
      nxt      = target;
      hcnt_nxt = '0;
      cand_nxt = S_OFF;
    end else if (target == cur) begin
      hcnt_nxt = '0;
    end else begin
      n   = (target == cand) ? ({1'b0, hcnt} + 1'b1) : (HW+1)'(1);
      req = (target > cur) ? UP_HOLD : DOWN_HOLD;
      if (int'(n) >= req) begin
        nxt      = target;
        hcnt_nxt = '0;
      end else begin
        hcnt_nxt = n[HW-1:0];
        cand_nxt = target;
      end
    end
  end

  assign period_end = (cur == S_FAST) ? (int'(pcnt) == FAST_PERIOD - 1)
                                      : (int'(pcnt) == SLOW_PERIOD - 1);

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      divcnt <= '0;
      tick   <= 1'b0;
      wipe   <= 1'b0;
      drops  <= '0;
      cur    <= S_OFF;
      cand   <= S_OFF;
      hcnt   <= '0;
      pcnt   <= '0;
      sweeps <= '0;
    end else begin
      divcnt <= (int'(divcnt) == DIV - 1) ? '0 : divcnt + 1'b1;
      tick   <= (int'(divcnt) == DIV - 1);
      wipe   <= 1'b0;
      if (tick) begin
        drops <= DW'($countones(rain));
        cur   <= nxt;
        hcnt  <= hcnt_nxt;
        cand  <= cand_nxt;
        // A state change takes priority over a completing sweep.
        if (nxt != cur || cur == S_OFF) begin
          pcnt <= '0;
        end else if (period_end) begin
          pcnt   <= '0;
          wipe   <= 1'b1;
          sweeps <= sweeps + 8'd1;
        end else begin
          pcnt <= pcnt + 1'b1;
        end
      end
    end
  end

endmodule
